// File: rtl/ir_pkg.sv
// Shared constants and helpers for the instruction register / prefetch queue.
package ir_pkg;

    // Default geometry of the instruction register queue.
    localparam int IR_WIDTH = 16;
    localparam int IR_DEPTH = 4;
    localparam int IR_OPW   = 4;

    // Field positions inside a default-width instruction word, for later decode.
    localparam int IR_RA_MSB  = 11;
    localparam int IR_RA_LSB  = 8;
    localparam int IR_RB_MSB  = 7;
    localparam int IR_RB_LSB  = 4;
    localparam int IR_IMM_MSB = 7;
    localparam int IR_IMM_LSB = 0;

    // Opcode of a default-width instruction word: the top IR_OPW bits.
    function automatic logic [IR_OPW-1:0] ir_opcode(input logic [IR_WIDTH-1:0] inst);
        return inst[IR_WIDTH-1 -: IR_OPW];
    endfunction

endpackage

// File: rtl/ir_fifo_ram.sv
// Queue storage: DEPTH x WIDTH array, synchronous write, asynchronous read, no reset.
module ir_fifo_ram
    import ir_pkg::*;
#(
    parameter int WIDTH = IR_WIDTH,
    parameter int DEPTH = IR_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ir_queue.sv
// Instruction register fronted by a DEPTH-entry prefetch queue.
// The RAM holds every queued word (head included); IRout is a registered copy
// of the head so the state machine sees a stable word for the whole cycle.
module ir_queue
    import ir_pkg::*;
#(
    parameter int WIDTH = IR_WIDTH,
    parameter int DEPTH = IR_DEPTH,
    parameter int OPW   = IR_OPW
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [WIDTH-1:0]           Inst,
    input  logic                       InstValid,
    output logic                       InstReady,
    input  logic                       Id,
    input  logic                       Flush,
    output logic [WIDTH-1:0]           IRout,
    output logic                       IRValid,
    output logic [OPW-1:0]             Opcode,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] irout_q, irout_d;
    logic             irvalid_q, irvalid_d;

    logic             push, pop;
    logic             ram_we;
    logic [PW-1:0]    next_addr;
    logic [WIDTH-1:0] next_word;

    // Ready depends only on the registered count, never on Id.
    assign InstReady = (count_q < CNT_MAX);
    assign push      = InstValid & InstReady;
    assign pop       = Id & irvalid_q;

    // The entry behind the head is what moves into IRout on a pop.
    assign next_addr = rptr_q + PTR_ONE;

    ir_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (Clk),
        .we_i    (ram_we),
        .waddr_i (wptr_q),
        .wdata_i (Inst),
        .raddr_i (next_addr),
        .rdata_o (next_word)
    );

    // Next-state: flush wins, otherwise apply push/pop with bypass into IRout.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        irout_d   = irout_q;
        irvalid_d = irvalid_q;
        ram_we    = 1'b0;

        if (Flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            count_d   = '0;
            irvalid_d = 1'b0;
        end else begin
            if (push) begin
                ram_we = 1'b1;
                wptr_d = wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10: begin
                    count_d = count_q + CNT_ONE;
                    if (count_q == '0) begin
                        irout_d   = Inst;
                        irvalid_d = 1'b1;
                    end
                end
                2'b01: begin
                    count_d = count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        irvalid_d = 1'b0;
                    end else begin
                        irout_d = next_word;
                    end
                end
                2'b11: begin
                    // Single entry: the incoming word becomes the head directly.
                    if (count_q == CNT_ONE) begin
                        irout_d = Inst;
                    end else begin
                        irout_d = next_word;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            irout_q   <= '0;
            irvalid_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            irout_q   <= irout_d;
            irvalid_q <= irvalid_d;
        end
    end

    assign IRout   = irout_q;
    assign IRValid = irvalid_q;
    assign Count   = count_q;
    assign Opcode  = irout_q[WIDTH-1 -: OPW];

endmodule

// File: tb/tb_ir_queue.sv
// Bench for ir_queue: directed steps plus random traffic against a queue model.
module tb_ir_queue;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int O  = 4;
    localparam int CW = $clog2(D + 1);

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic [W-1:0]  Inst = '0;
    logic          InstValid = 1'b0;
    logic          Id = 1'b0;
    logic          Flush = 1'b0;
    logic          InstReady;
    logic [W-1:0]  IRout;
    logic          IRValid;
    logic [O-1:0]  Opcode;
    logic [CW-1:0] Count;

    ir_queue #(.WIDTH(W), .DEPTH(D), .OPW(O)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Inst      (Inst),
        .InstValid (InstValid),
        .InstReady (InstReady),
        .Id        (Id),
        .Flush     (Flush),
        .IRout     (IRout),
        .IRValid   (IRValid),
        .Opcode    (Opcode),
        .Count     (Count)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the list of queued words plus the visible head register.
    logic [W-1:0] mq [$];
    logic [W-1:0] m_ir  = '0;
    logic         m_vld = 1'b0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] h;
        h = m_ir;
        cmp({tag, ".IRout"},     32'(IRout),     32'(m_ir));
        cmp({tag, ".IRValid"},   32'(IRValid),   32'(m_vld));
        cmp({tag, ".Count"},     32'(Count),     32'(mq.size()));
        cmp({tag, ".InstReady"}, 32'(InstReady), 32'(mq.size() < D));
        cmp({tag, ".Opcode"},    32'(Opcode),    32'(h[W-1 -: O]));
    endtask

    // Apply the current inputs to the model as one clock edge would.
    task automatic model_edge();
        bit rdy, pu, po;
        rdy = (mq.size() < D);
        if (Flush) begin
            mq.delete();
            m_vld = 1'b0;
        end else begin
            pu = InstValid && rdy;
            po = Id && m_vld;
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back(Inst);
            if (mq.size() > 0) begin
                m_ir  = mq[0];
                m_vld = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic id, input logic fl);
        InstValid = iv;
        Inst      = d;
        Id        = id;
        Flush     = fl;
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] words [4];
        logic [W-1:0] saved;
        logic [W-1:0] seq;
        words[0] = 16'h1111; words[1] = 16'h2222;
        words[2] = 16'h3333; words[3] = 16'h4444;

        // Reset state while Reset_n is low.
        #1;
        check_all("reset");
        cmp("reset.ready", 32'(InstReady), 32'd1);
        @(negedge Clk);
        Reset_n = 1'b1;
        cycle("idle");

        // Single push into empty queue, then hold.
        drive(1'b1, 16'h2010, 1'b0, 1'b0);
        cycle("push1");
        cmp("push1.ir", 32'(IRout), 32'h2010);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (5) cycle("hold");
        cmp("hold.ir", 32'(IRout), 32'h2010);
        cmp("hold.cnt", 32'(Count), 32'd1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        cycle("pop1");

        // Fill to full, overflow attempt, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, words[i], 1'b0, 1'b0);
            cycle("fill");
        end
        cmp("full.ready", 32'(InstReady), 32'd0);
        drive(1'b1, 16'h5555, 1'b0, 1'b0);
        repeat (2) cycle("ovf");
        cmp("ovf.cnt", 32'(Count), 32'd4);
        drive(1'b0, 16'h5555, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cmp("drain.head", 32'(IRout), 32'(words[i]));
            drive(1'b0, 16'h0000, 1'b1, 1'b0);
            cycle("drain");
        end
        cmp("drain.vld", 32'(IRValid), 32'd0);
        cmp("drain.ir", 32'(IRout), 32'h4444);

        // Simultaneous push and pop at Count=1 and Count=3.
        drive(1'b1, 16'hAAAA, 1'b0, 1'b0);
        cycle("pa");
        drive(1'b1, 16'hBBBB, 1'b1, 1'b0);
        cycle("pp1");
        cmp("pp1.ir", 32'(IRout), 32'hBBBB);
        cmp("pp1.cnt", 32'(Count), 32'd1);
        drive(1'b1, 16'hCCCC, 1'b0, 1'b0);
        cycle("pc");
        drive(1'b1, 16'hDDDD, 1'b0, 1'b0);
        cycle("pd");
        drive(1'b1, 16'hEEEE, 1'b1, 1'b0);
        cycle("pp3a");
        cmp("pp3a.ir", 32'(IRout), 32'hCCCC);
        cmp("pp3a.cnt", 32'(Count), 32'd3);
        drive(1'b1, 16'hF00F, 1'b1, 1'b0);
        cycle("pp3b");
        cmp("pp3b.ir", 32'(IRout), 32'hDDDD);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (3) cycle("ppdrain");
        cmp("ppdrain.last", 32'(IRout), 32'hF00F);

        // Flush with simultaneous push and pop.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
            cycle("pf");
        end
        saved = IRout;
        drive(1'b1, 16'h7777, 1'b1, 1'b1);
        cycle("flush");
        cmp("flush.cnt", 32'(Count), 32'd0);
        cmp("flush.vld", 32'(IRValid), 32'd0);
        cmp("flush.ir", 32'(IRout), 32'(saved));
        drive(1'b1, 16'h8888, 1'b0, 1'b0);
        cycle("postflush");
        cmp("postflush.ir", 32'(IRout), 32'h8888);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        cycle("pf.pop");

        // Interleaved incrementing sequence across several pointer wraps.
        seq = 16'h0A00;
        for (int i = 0; i < 3 * D; i++) begin
            drive(1'b1, seq, (i % 3) != 0, 1'b0);
            seq = seq + 16'h1;
            cycle("wrap");
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (D + 1) cycle("wrapdrain");
        cmp("under.cnt", 32'(Count), 32'd0);
        cycle("under");

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom % 4) != 0, W'($urandom), ($urandom % 2) == 1, ($urandom % 20) == 0);
            cycle("rand");
        end

        // Asynchronous reset mid-burst with two entries queued.
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle("preflush");
        drive(1'b1, 16'h1234, 1'b0, 1'b0);
        cycle("ar1");
        drive(1'b1, 16'h5678, 1'b0, 1'b0);
        cycle("ar2");
        cmp("ar.cnt", 32'(Count), 32'd2);
        #3;
        Reset_n = 1'b0;
        #1;
        mq.delete();
        m_ir  = '0;
        m_vld = 1'b0;
        check_all("areset");
        #2;
        Reset_n = 1'b1;
        drive(1'b1, 16'h9999, 1'b0, 1'b0);
        cycle("afterrst");
        cmp("afterrst.ir", 32'(IRout), 32'h9999);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register with a prefetch queue. It sits between instruction memory and the control state machine, replacing the single-entry load/hold register. Up to DEPTH fetched instructions are buffered. The head instruction is presented as a registered IRout with a valid flag and decoded opcode, and a Flush input discards all buffered entries on a control-flow change.

## Interface
- WIDTH, 16, instruction width in bits (≥ 8)
- DEPTH, 4, queue capacity in instructions (power of 2, ≥ 2)
- OPW, 4, opcode field width; opcode is IRout[WIDTH-1 -: OPW]
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- Inst  input  WIDTH  instruction word from instruction memory
- InstValid  input  1  Inst is valid this cycle (push request)
- InstReady  output  1  queue can accept a push this cycle
- Id  input  1  state machine consumes the head instruction (pop request)
- Flush  input  1  discard all queued instructions
- IRout  output  WIDTH  current head instruction (registered)
- IRValid  output  1  IRout holds an unconsumed instruction
- Opcode  output  OPW  IRout[WIDTH-1 -: OPW], combinational slice
- Count  output  $clog2(DEPTH+1)  number of queued instructions, head included

## Operation
- **Reset** (asynchronous, while Reset_n=0):
  - IRout=0, IRValid=0, Count=0, InstReady=1.
  - Read/write pointers=0; storage contents don't-care.
- **Signals:**
  - push = InstValid & InstReady
  - pop = Id & IRValid
  - InstReady = (Count < DEPTH). It is registered-state only, with no combinational path from Id.
- **Priority:** Flush > (push, pop).
  - Flush: Count←0, pointers←0, IRValid←0, IRout holds its value.
  - Push and pop in the flush cycle are ignored.
- **Push only:**
  - Inst is written at the write pointer; Count+1.
  - If the queue was empty, IRout←Inst and IRValid←1 at the same edge (bypass).
- **Pop only:**
  - Count−1.
  - If Count was ≥2, IRout←next entry and IRValid stays 1.
  - If Count was 1, IRValid←0 and IRout holds.
- **Push and pop together:**
  - Count is unchanged.
  - If Count was 1, IRout←Inst (bypass).
  - Otherwise IRout←next stored entry, and Inst is written behind it.
- **Ignored requests:**
  - Id with IRValid=0 is ignored (no underflow).
  - InstValid with InstReady=0 is ignored (no overflow; the producer must hold).
- **Pointer wrap:** pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count alone distinguishes full from empty.
- **Hold:** with no push, pop or flush, every output and all state hold. This matches the old Id=0 hold semantics.

## Timing
- Latency, push into empty queue: IRout/IRValid update at the same edge that accepts the push. They are visible one cycle after InstValid is sampled.
- Latency, pop: the next instruction appears on IRout at the edge that samples Id=1. Back-to-back pops sustain 1 instruction/cycle.
- Throughput: 1 push and 1 pop per cycle simultaneously, except when full. At full InstReady=0, so a simultaneous push is not accepted even with a pop.
- Reset mid-operation: all state clears immediately on Reset_n falling, independent of Clk. The first push is accepted at the first rising edge after Reset_n rises.
- Opcode follows IRout combinationally, so it is registered-stable for the whole cycle.

## Structure
- Package ir_pkg holds:
  - default constants IR_WIDTH=16, IR_DEPTH=4, IR_OPW=4
  - a function extracting the opcode from an instruction word
  - field position localparams for later decode use (register A/B nibbles, low 8-bit immediate)
- Sub-module ir_fifo_ram:
  - DEPTH×WIDTH storage array with write port (we, waddr, wdata) and asynchronous read port (raddr)
  - no reset on contents
- The top level owns the pointers, Count, IRout/IRValid and all control.

## Test plan
- Reset, then push 16'h2010 alone with Id=0 for 5 cycles -> IRout=16'h2010 and IRValid=1 from the accept edge onward, held stable; Count=1.
- Push 16'h1111, 16'h2222, 16'h3333, 16'h4444, then a 5th word 16'h5555 held valid -> InstReady=0 after the 4th push, Count=4, 16'h5555 not accepted. Pop 4 times -> IRout 1111, 2222, 3333, 4444 in order; after the 4th pop IRValid=0 and IRout holds 16'h4444.
- With Count=1 (IRout=16'hAAAA), assert Id and push 16'hBBBB in the same cycle -> IRout=16'hBBBB, IRValid=1, Count=1. With Count=3, simultaneous push and pop -> Count stays 3 and order is preserved.
- Fill 3 entries, assert Flush together with InstValid (16'h7777) and Id -> Count=0, IRValid=0, IRout unchanged, 16'h7777 dropped. The next push of 16'h8888 appears on IRout at its accept edge.
- Run 3×DEPTH interleaved pushes/pops of an incrementing sequence -> pointers wrap and output order matches input order. Id while empty -> no Count change and no underflow.
- Drop Reset_n asynchronously mid-burst with Count=2 -> IRout=0, IRValid=0, Count=0, InstReady=1 immediately, before the next Clk edge.
